// File: rtl/actor_handshake_responder.sv
// Trigger-driven streaming copy actor: bounded FIFO-to-FIFO burst per ap_start.
// Optional firing/invocation counters are enabled with ACTOR_FIRING_COUNTER_EN.
module actor_handshake_responder #(
  parameter int DATA_W      = 32,
  parameter int MAX_FIRINGS = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_ready,
  output logic              ap_idle,
  output logic [31:0]       ap_return,
  input  logic [DATA_W-1:0] in_dout,
  input  logic              in_empty_n,
  output logic              in_read,
  output logic [DATA_W-1:0] out_din,
  input  logic              out_full_n,
  output logic              out_write
`ifdef ACTOR_FIRING_COUNTER_EN
  ,
  output logic [31:0]       firing_total,
  output logic [31:0]       invocation_total
`endif
);

  localparam int CW = $clog2(MAX_FIRINGS + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_FIRINGS);

  // TriggerTypes encoding shared with the trigger.
  localparam logic [31:0] RET_IDLE     = 32'd0;
  localparam logic [31:0] RET_EXECUTED = 32'd1;
  localparam logic [31:0] RET_CONTINUE = 32'd2;
  localparam logic [31:0] RET_WAIT     = 32'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [31:0]   ret_q, ret_nxt;
  logic [31:0]   ret_code;
  logic          fire;

  always_comb begin
    fire = (state == S_FIRE) & in_empty_n & out_full_n
         & (count < MAX_C);
  end

  // Budget exhaustion only means CONTINUE if work is still queued.
  always_comb begin
    ret_code = RET_WAIT;
    if ((count == MAX_C) && in_empty_n)
      ret_code = RET_CONTINUE;
    else if (count != '0)
      ret_code = RET_EXECUTED;
    else if (!in_empty_n)
      ret_code = RET_IDLE;
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    ret_nxt   = ret_q;
    unique case (state)
      S_IDLE: begin
        if (ap_start) begin
          state_nxt = S_FIRE;
          count_nxt = '0;
        end
      end
      S_FIRE: begin
        if (fire) begin
          count_nxt = count + CW'(1);
        end else begin
          ret_nxt   = ret_code;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= S_IDLE;
      count <= '0;
      ret_q <= RET_IDLE;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      ret_q <= ret_nxt;
    end
  end

  always_comb begin
    ap_done   = (state == S_DONE);
    ap_ready  = ap_done;
    ap_idle   = (state == S_IDLE);
    ap_return = ret_q;
    in_read   = fire;
    out_write = fire;
    out_din   = fire ? in_dout : '0;
  end

`ifdef ACTOR_FIRING_COUNTER_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      firing_total     <= '0;
      invocation_total <= '0;
    end else begin
      if (fire && (firing_total != '1))
        firing_total <= firing_total + 32'd1;
      if (ap_done && (invocation_total != '1))
        invocation_total <= invocation_total + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_actor_handshake_responder.sv
// Directed bench for actor_handshake_responder with behavioural FIFO models.
// Counter checks are compiled in with ACTOR_FIRING_COUNTER_EN.
module tb_actor_handshake_responder;

  localparam int DATA_W = 32;
  localparam logic [31:0] R_IDLE = 32'd0;
  localparam logic [31:0] R_EXEC = 32'd1;
  localparam logic [31:0] R_CONT = 32'd2;
  localparam logic [31:0] R_WAIT = 32'd3;

  logic              ap_clk;
  logic              ap_rst_n;
  logic              ap_start;
  logic              ap_done;
  logic              ap_ready;
  logic              ap_idle;
  logic [31:0]       ap_return;
  logic [DATA_W-1:0] in_dout;
  logic              in_empty_n;
  logic              in_read;
  logic [DATA_W-1:0] out_din;
  logic              out_full_n;
  logic              out_write;
`ifdef ACTOR_FIRING_COUNTER_EN
  logic [31:0]       firing_total;
  logic [31:0]       invocation_total;
`endif

  actor_handshake_responder #(
    .DATA_W(DATA_W),
    .MAX_FIRINGS(16)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .ap_start(ap_start),
    .ap_done(ap_done),
    .ap_ready(ap_ready),
    .ap_idle(ap_idle),
    .ap_return(ap_return),
    .in_dout(in_dout),
    .in_empty_n(in_empty_n),
    .in_read(in_read),
    .out_din(out_din),
    .out_full_n(out_full_n),
    .out_write(out_write)
`ifdef ACTOR_FIRING_COUNTER_EN
    ,
    .firing_total(firing_total),
    .invocation_total(invocation_total)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] in_mem [64];
  logic [31:0] out_mem [64];
  int head = 0;
  int tail = 0;
  int out_wr = 0;
  int out_base = 0;
  int out_cap = 0;

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  assign in_empty_n = (tail != head);
  assign in_dout    = in_mem[head % 64];
  assign out_full_n = ((out_wr - out_base) < out_cap);

  always @(posedge ap_clk) begin
    if (in_read) head <= head + 1;
    if (out_write) begin
      out_mem[out_wr % 64] <= out_din;
      out_wr <= out_wr + 1;
    end
  end

  task automatic push(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      in_mem[tail % 64] = first + 32'(i);
      tail = tail + 1;
    end
  endtask

  task automatic set_space(input int cap);
    out_base = out_wr;
    out_cap  = cap;
  endtask

  // Pulses ap_start and observes one invocation, cycle 1 = after acceptance.
  task automatic invoke(output int lat, output int nw,
                        output int fw, output int lw,
                        output bit bad);
    lat = -1; nw = 0; fw = -1; lw = -1; bad = 0;
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge ap_clk);
      if (in_read !== out_write) bad = 1;
      if (in_read && !(in_empty_n && out_full_n)) bad = 1;
      if (ap_ready !== ap_done) bad = 1;
      if (out_write) begin
        nw++;
        if (fw < 0) fw = k;
        lw = k;
      end
      if (ap_done) begin
        lat = k;
        break;
      end
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_reset;
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    checks++;
    if ({ap_idle, ap_done, ap_ready, in_read, out_write} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 10000",
               {ap_idle, ap_done, ap_ready, in_read, out_write});
    end
    checks++;
    if (ap_return !== R_IDLE || out_din !== '0) begin
      errors++;
      $display("FAIL reset_data: ret %0d din %h required 0 0",
               ap_return, out_din);
    end
`ifdef ACTOR_FIRING_COUNTER_EN
    checks++;
    if (firing_total !== 0 || invocation_total !== 0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d %0d required 0 0",
               firing_total, invocation_total);
    end
`endif
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    checks++;
    if (ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: got %b required 1", ap_idle);
    end
  endtask

  task automatic test_burst;
    int lat, nw, fw, lw, b0;
    bit bad;
    push(32'hA0, 5);
    set_space(8);
    b0 = out_base;
    invoke(lat, nw, fw, lw, bad);
    checks++;
    if (nw !== 5 || fw !== 1 || lw !== 5) begin
      errors++;
      $display("FAIL burst_writes: n %0d first %0d last %0d required 5 1 5",
               nw, fw, lw);
    end
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL burst_latency: got %0d required 7", lat);
    end
    checks++;
    if (ap_return !== R_EXEC) begin
      errors++;
      $display("FAIL burst_ret: got %0d required %0d", ap_return, R_EXEC);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_mem[(b0 + i) % 64] !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL burst_data[%0d]: got %h required %h", i,
                 out_mem[(b0 + i) % 64], 32'hA0 + 32'(i));
      end
    end
    checks++;
    if (bad !== 1'b0 || ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL burst_protocol: bad %b idle %b required 0 1",
               bad, ap_idle);
    end
  endtask

  task automatic test_budget;
    int lat, nw, fw, lw, b0;
    bit bad;
    push(32'hB00, 20);
    set_space(64);
    b0 = out_base;
    invoke(lat, nw, fw, lw, bad);
    checks++;
    if (nw !== 16 || lat !== 18 || ap_return !== R_CONT) begin
      errors++;
      $display("FAIL budget_first: n %0d lat %0d ret %0d required 16 18 %0d",
               nw, lat, ap_return, R_CONT);
    end
    invoke(lat, nw, fw, lw, bad);
    checks++;
    if (nw !== 4 || lat !== 6 || ap_return !== R_EXEC) begin
      errors++;
      $display("FAIL budget_second: n %0d lat %0d ret %0d required 4 6 %0d",
               nw, lat, ap_return, R_EXEC);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_mem[(b0 + i) % 64] !== 32'hB00 + 32'(i)) begin
        errors++;
        $display("FAIL budget_data[%0d]: got %h required %h", i,
                 out_mem[(b0 + i) % 64], 32'hB00 + 32'(i));
      end
    end
`ifdef ACTOR_FIRING_COUNTER_EN
    checks++;
    if (firing_total !== 25 || invocation_total !== 3) begin
      errors++;
      $display("FAIL counters: got %0d %0d required 25 3",
               firing_total, invocation_total);
    end
`endif
  endtask

  task automatic test_empty;
    int lat, nw, fw, lw;
    bit bad;
    set_space(64);
    invoke(lat, nw, fw, lw, bad);
    checks++;
    if (nw !== 0 || lat !== 2 || ap_return !== R_IDLE) begin
      errors++;
      $display("FAIL empty: n %0d lat %0d ret %0d required 0 2 %0d",
               nw, lat, ap_return, R_IDLE);
    end
  endtask

  task automatic test_exact_budget;
    int lat, nw, fw, lw;
    bit bad;
    push(32'hD0, 16);
    set_space(64);
    invoke(lat, nw, fw, lw, bad);
    checks++;
    if (nw !== 16 || lat !== 18 || ap_return !== R_EXEC) begin
      errors++;
      $display("FAIL exact_budget: n %0d lat %0d ret %0d required 16 18 %0d",
               nw, lat, ap_return, R_EXEC);
    end
  endtask

  task automatic test_wait;
    int lat, nw, fw, lw, b0;
    bit bad;
    push(32'hE0, 3);
    set_space(0);
    invoke(lat, nw, fw, lw, bad);
    checks++;
    if (nw !== 0 || lat !== 2 || ap_return !== R_WAIT) begin
      errors++;
      $display("FAIL wait: n %0d lat %0d ret %0d required 0 2 %0d",
               nw, lat, ap_return, R_WAIT);
    end
    set_space(2);
    b0 = out_base;
    invoke(lat, nw, fw, lw, bad);
    checks++;
    if (nw !== 2 || lat !== 4 || ap_return !== R_EXEC || bad !== 1'b0) begin
      errors++;
      $display("FAIL full_mid: n %0d lat %0d ret %0d bad %b required 2 4 %0d 0",
               nw, lat, ap_return, bad, R_EXEC);
    end
    checks++;
    if (out_mem[b0 % 64] !== 32'hE0 || out_mem[(b0 + 1) % 64] !== 32'hE1) begin
      errors++;
      $display("FAIL full_mid_data: got %h %h required e0 e1",
               out_mem[b0 % 64], out_mem[(b0 + 1) % 64]);
    end
    set_space(64);
    invoke(lat, nw, fw, lw, bad);
    checks++;
    if (nw !== 1 || ap_return !== R_EXEC) begin
      errors++;
      $display("FAIL drain: n %0d ret %0d required 1 %0d", nw, ap_return, R_EXEC);
    end
  endtask

  task automatic test_reset_mid;
    int lat, nw, fw, lw, b0;
    bit bad;
    push(32'hC0, 10);
    set_space(64);
    b0 = out_base;
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    checks++;
    if (in_read !== 1'b1) begin
      errors++;
      $display("FAIL mid_firing: in_read %b required 1", in_read);
    end
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if ({ap_idle, ap_done, ap_ready, in_read, out_write} !== 5'b10000 ||
        ap_return !== R_IDLE || out_din !== '0) begin
      errors++;
      $display("FAIL async_reset: ctrl %b ret %0d din %h required 10000 0 0",
               {ap_idle, ap_done, ap_ready, in_read, out_write},
               ap_return, out_din);
    end
    checks++;
    if (out_wr - b0 !== 3) begin
      errors++;
      $display("FAIL reset_popped: got %0d required 3", out_wr - b0);
    end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    checks++;
    if (ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_mid_reset: got %b required 1", ap_idle);
    end
    b0 = out_wr;
    invoke(lat, nw, fw, lw, bad);
    checks++;
    if (nw !== 7 || lat !== 9 || ap_return !== R_EXEC) begin
      errors++;
      $display("FAIL resume: n %0d lat %0d ret %0d required 7 9 %0d",
               nw, lat, ap_return, R_EXEC);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (out_mem[(b0 + i) % 64] !== 32'hC3 + 32'(i)) begin
        errors++;
        $display("FAIL resume_data[%0d]: got %h required %h", i,
                 out_mem[(b0 + i) % 64], 32'hC3 + 32'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_budget();
    test_empty();
    test_exact_budget();
    test_wait();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/actor_handshake_responder.md
Name: actor_handshake_responder

Overview:
- Actor-side responder to a trigger's actor_start / actor_done / actor_return handshake.
- Wraps a streaming copy actor: on each invocation it performs a bounded burst of single-token firings from an input HLS FIFO to an output HLS FIFO.
- It then reports a TriggerTypes return code telling the trigger whether to relaunch, sleep or go idle.
- Serves as the hardware reference actor for trigger integration and as a pass-through/repeater actor in networks.

Parameters:
- DATA_W, 32, token width in bits.
- MAX_FIRINGS, 16, firing budget per invocation (>=1); count register width = $clog2(MAX_FIRINGS+1).

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- ap_start  in  1  invocation request (driven by trigger actor_start)
- ap_done  out  1  one-cycle pulse: invocation complete, ap_return valid
- ap_ready  out  1  equal to ap_done
- ap_idle  out  1  high while in S_IDLE
- ap_return  out  32  TriggerTypes return code; held from ap_done until the next ap_done
- in_dout  in  DATA_W  head token of input FIFO (first-word fall-through)
- in_empty_n  in  1  input FIFO non-empty
- in_read  out  1  pop input FIFO this cycle
- out_din  out  DATA_W  token written to output FIFO
- out_full_n  in  1  output FIFO not full
- out_write  out  1  push output FIFO this cycle

Behaviour:
- Reset (async assert, sync release): state=S_IDLE, count=0, ap_return=IDLE, ap_done=ap_ready=0, ap_idle=1, in_read=out_write=0, out_din=0.
- FSM states: S_IDLE, S_FIRE, S_DONE.
- S_IDLE:
  - ap_start=1 -> S_FIRE, count<=0.
  - Otherwise stay in S_IDLE.
  - ap_start is sampled only in S_IDLE; ap_start asserted in other states is ignored.
- S_FIRE, fire condition = in_empty_n & out_full_n & (count<MAX_FIRINGS):
  - When fire is true: in_read=1, out_write=1, out_din=in_dout combinationally in the same cycle; count<=count+1; stay in S_FIRE.
  - When fire is false: register ap_return, then -> S_DONE. Return code priority:
    - count==MAX_FIRINGS & in_empty_n -> CONTINUE
    - count>0 -> EXECUTED
    - count==0 & ~in_empty_n -> IDLE
    - count==0 & in_empty_n & ~out_full_n -> WAIT
- S_DONE: ap_done=ap_ready=1 for exactly one cycle -> S_IDLE.
- Latency:
  - ap_start accepted -> first possible firing 1 cycle later.
  - ap_done occurs count+2 cycles after the ap_start acceptance edge.
  - Minimum invocation (zero firings) = ap_done 2 cycles after acceptance.
- Throughput: one token per cycle while both FIFOs allow it; a FIFO status change mid-burst ends the burst that cycle.
- Outputs: in_read and out_write are never asserted outside S_FIRE, are always equal, and are never asserted when in_empty_n=0 or out_full_n=0.
- Boundaries:
  - count saturates at MAX_FIRINGS; no wrap-around.
  - MAX_FIRINGS=1 is legal.
  - Simultaneous in_empty_n fall and budget exhaustion -> EXECUTED, not CONTINUE.
- Reset mid-burst: immediate return to reset values. A token popped in the reset cycle is not re-sent; the trigger is reset by the same reset.

Optional Feature:
- Macro: ACTOR_FIRING_COUNTER_EN.
- Defined:
  - Adds output firing_total[31:0], incremented on every firing and saturating at 32'hFFFF_FFFF.
  - Adds output invocation_total[31:0], incremented on each ap_done and saturating at 32'hFFFF_FFFF.
  - Both reset to 0 and are readable at any time.
- Undefined: neither port nor its registers exist; all other behaviour is identical.

Test Plan:
- Input FIFO preloaded with 5 tokens (0xA0..0xA4), output space 8, MAX_FIRINGS=16, single ap_start pulse -> out_write high for 5 consecutive cycles with 0xA0..0xA4 in order; ap_return=EXECUTED; ap_done 7 cycles after acceptance.
- Input holds 20 tokens, MAX_FIRINGS=16 -> 16 tokens moved, ap_return=CONTINUE; second ap_start -> 4 moved, ap_return=EXECUTED.
- Empty input, ap_start -> no in_read, ap_return=IDLE, ap_done exactly 2 cycles after acceptance.
- Input holds 3 tokens, out_full_n=0 -> zero firings, ap_return=WAIT. Same setup with out_full_n dropping after 2 firings -> 2 tokens moved, ap_return=EXECUTED.
- Drive ap_rst_n low during the 3rd firing of a 10-token burst -> all outputs return to reset values asynchronously. After release, ap_idle=1 and a new ap_start moves the remaining 7 tokens.
- With ACTOR_FIRING_COUNTER_EN defined, run scenarios 1 and 2 back to back -> firing_total=25, invocation_total=3.
